// File: rtl/regfile_ctx_if.sv
// Context engine bus bundle: command channel, save/restore word streams, register file port, status.
interface regfile_ctx_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int IDX_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [IDX_W-1:0]  cmd_first;
  logic [IDX_W-1:0]  cmd_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        rf_rd_en;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_data_in;
  logic [1:0]        rf_wr_en;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_data_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_op, cmd_first, cmd_last, out_ready, in_valid, in_data, rf_data_in,
    output cmd_ready, out_valid, out_data, in_ready, rf_rd_en, rf_rd_addr, rf_wr_en,
           rf_wr_addr, rf_data_out, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_first, cmd_last, out_ready, in_valid, in_data, rf_data_in,
    input  cmd_ready, out_valid, out_data, in_ready, rf_rd_en, rf_rd_addr, rf_wr_en,
           rf_wr_addr, rf_data_out, busy, done, err
  );
endinterface

// File: rtl/regfile_context_engine.sv
// Register file context spill/fill engine: saves a register range to a word stream or restores it.
// Optional trailing XOR checksum word when REGFILE_CTX_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// S_RD  | read strobe for register idx
// S_CAP | capture read data into the output word
// S_OUT | hold output word until out_ready
// R_WR  | accept inbound words, write register idx on each one
// FIN   | done (or checksum err) pulse, return to IDLE
module regfile_context_engine #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 10
) (
  input logic           clock,
  input logic           nreset,
  regfile_ctx_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [2:0] {IDLE, S_RD, S_CAP, S_OUT, R_WR, FIN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, last_q;
  logic              busy_q, err_q, out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              cmd_acc, range_bad, out_hs, in_hs, wr_hs, at_last;
  logic              end_save, end_restore, chk_bad;

  assign cmd_acc   = bus.cmd_valid & (state_q == IDLE);
  assign range_bad = bus.cmd_first > bus.cmd_last;
  assign out_hs    = (state_q == S_OUT) & bus.out_ready;
  assign in_hs     = (state_q == R_WR) & bus.in_valid;
  assign at_last   = idx_q == last_q;

`ifdef REGFILE_CTX_CHECKSUM_EN
  logic              chk_phase_q, chk_bad_q;
  logic [DATA_W-1:0] xor_q;

  // Once the last register has moved, one more stream word carries the checksum.
  assign wr_hs       = in_hs & ~chk_phase_q;
  assign end_save    = out_hs & chk_phase_q;
  assign end_restore = in_hs & chk_phase_q;
  assign chk_bad     = chk_bad_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      chk_phase_q <= 1'b0;
      chk_bad_q   <= 1'b0;
      xor_q       <= '0;
    end else begin
      if (cmd_acc) begin
        chk_phase_q <= 1'b0;
        chk_bad_q   <= 1'b0;
        xor_q       <= '0;
      end
      if (state_q == S_CAP) xor_q <= xor_q ^ bus.rf_data_in;
      if (wr_hs) xor_q <= xor_q ^ bus.in_data;
      if ((out_hs | wr_hs) & at_last & ~chk_phase_q) chk_phase_q <= 1'b1;
      if (end_restore) chk_bad_q <= bus.in_data != xor_q;
    end
  end
`else
  assign wr_hs       = in_hs;
  assign end_save    = out_hs & at_last;
  assign end_restore = in_hs & at_last;
  assign chk_bad     = 1'b0;
`endif

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (cmd_acc && !range_bad) state_d = bus.cmd_op ? R_WR : S_RD;
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = S_OUT;
      S_OUT: begin
        if (end_save)               state_d = FIN;
        else if (out_hs && !at_last) state_d = S_RD;
      end
      R_WR:  if (end_restore) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      idx_q       <= '0;
      last_q      <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      err_q <= cmd_acc & range_bad;
      if (cmd_acc) begin
        idx_q  <= bus.cmd_first;
        last_q <= bus.cmd_last;
        busy_q <= ~range_bad;
      end
      if (state_q == FIN) busy_q <= 1'b0;
      if (state_q == S_CAP) begin
        out_data_q  <= bus.rf_data_in;
        out_valid_q <= 1'b1;
      end
      if (out_hs) begin
        out_valid_q <= 1'b0;
        if (!at_last) idx_q <= idx_q + IDX_W'(1);
`ifdef REGFILE_CTX_CHECKSUM_EN
        else if (!chk_phase_q) begin
          out_data_q  <= xor_q;
          out_valid_q <= 1'b1;
        end
`endif
      end
      if (wr_hs && !at_last) idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Write strobe is combinational on the inbound handshake; the index stays registered.
  assign bus.cmd_ready   = state_q == IDLE;
  assign bus.in_ready    = state_q == R_WR;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.rf_rd_en    = (state_q == S_RD) ? 2'b11 : 2'b00;
  assign bus.rf_rd_addr  = (state_q == S_RD) ? {{(ADDR_W-IDX_W){1'b0}}, idx_q} : '0;
  assign bus.rf_wr_en    = wr_hs ? 2'b11 : 2'b00;
  assign bus.rf_wr_addr  = wr_hs ? {{(ADDR_W-IDX_W){1'b0}}, idx_q} : '0;
  assign bus.rf_data_out = wr_hs ? bus.in_data : '0;
  assign bus.busy        = busy_q;
  assign bus.done        = (state_q == FIN) & ~chk_bad;
  assign bus.err         = err_q | ((state_q == FIN) & chk_bad);
endmodule

// File: tb/tb_regfile_context_engine.sv
// Randomized bench for regfile_context_engine with a register-file memory model and a range-level reference.
module tb_regfile_context_engine;
  logic clock = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  regfile_ctx_if #(.DATA_W(16), .ADDR_W(10), .IDX_W(4)) bus();

  regfile_context_engine #(.DATA_W(16), .NUM_REGS(16), .ADDR_W(10)) dut (
    .clock (clock),
    .nreset(nreset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Register file memory: 1-cycle read latency, written on full-lane write strobe.
  logic [15:0] rf_mem [16];
  logic        preload_req = 1'b0;
  always @(posedge clock) begin
    if (preload_req)
      for (int i = 0; i < 16; i++) rf_mem[i] <= 16'(16'h1000 + i);
    if (bus.rf_wr_en == 2'b11) rf_mem[bus.rf_wr_addr[3:0]] <= bus.rf_data_out;
    if (bus.rf_rd_en == 2'b11) bus.rf_data_in <= rf_mem[bus.rf_rd_addr[3:0]];
  end

  // Observer, sampled mid-cycle.
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int overlap_cnt = 0, hold_bad_cnt = 0, hi_bad_cnt = 0, lane_bad_cnt = 0;
  logic [15:0] got_words[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  always @(negedge clock) begin
    if (!nreset) prev_stall = 1'b0;
    else begin
      if (bus.rf_rd_en != 2'b00) begin
        rd_cnt++;
        if (bus.rf_rd_en != 2'b11) lane_bad_cnt++;
        if (bus.rf_rd_addr[9:4] != 6'd0) hi_bad_cnt++;
      end
      if (bus.rf_wr_en != 2'b00) begin
        wr_cnt++;
        if (bus.rf_wr_en != 2'b11) lane_bad_cnt++;
        if (bus.rf_wr_addr[9:4] != 6'd0) hi_bad_cnt++;
      end
      if (bus.rf_rd_en != 2'b00 && bus.rf_wr_en != 2'b00) overlap_cnt++;
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
      if (bus.out_valid && bus.out_ready) got_words.push_back(bus.out_data);
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) hold_bad_cnt++;
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  logic [15:0] ref_regs [16];
  logic [15:0] none[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // rmode: 0 = sink always ready, 1 = random ready, 2 = ready only after 10 stalled cycles per word
  task automatic do_op(input bit op, input int first, input int last, input int rmode,
                       input logic [15:0] din[$], input bit use_bad, input logic [15:0] bad_val);
    logic [15:0] exp_q[$];
    logic [15:0] dat[$];
    logic [15:0] in_q[$];
    logic [15:0] x;
    bit exp_err, fin, hs;
    int n, r0, w0, d0, e0, g0, hc;
    exp_err = first > last;
    n = exp_err ? 0 : last - first + 1;
    x = '0;
    if (!exp_err) begin
      for (int i = first; i <= last; i++) begin
        logic [15:0] v;
        if (!op) v = ref_regs[i];
        else v = (din.size() > i - first) ? din[i - first] : 16'($urandom);
        if (!op) exp_q.push_back(v);
        else dat.push_back(v);
        x ^= v;
      end
      in_q = dat;
`ifdef REGFILE_CTX_CHECKSUM_EN
      if (!op) exp_q.push_back(x);
      else in_q.push_back(use_bad ? bad_val : x);
`endif
    end
`ifdef REGFILE_CTX_CHECKSUM_EN
    if (op && !exp_err && use_bad && bad_val != x) exp_err = 1'b1;
`endif
    r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt; g0 = got_words.size();
    check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_first = 4'(first);
    bus.cmd_last  = 4'(last);
    tick();
    bus.cmd_valid = 1'b0;
    fin = 1'b0;
    hc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (bus.done || bus.err) begin
        fin = 1'b1;
        break;
      end
      case (rmode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = $urandom_range(0, 2) != 0;
        default: begin
          if (bus.out_valid && !bus.out_ready) begin
            hc++;
            if (hc >= 10) bus.out_ready = 1'b1;
          end else if (!bus.out_valid) begin
            bus.out_ready = 1'b0;
            hc = 0;
          end
        end
      endcase
      if (op) begin
        bus.in_valid = (in_q.size() > 0) && ($urandom_range(0, 2) != 0);
        bus.in_data  = (in_q.size() > 0) ? in_q[0] : 16'($urandom);
      end else begin
        bus.in_valid = $urandom_range(0, 3) == 0;
        bus.in_data  = 16'($urandom);
      end
      bus.cmd_valid = $urandom_range(0, 3) == 0;
      bus.cmd_op    = 1'($urandom);
      bus.cmd_first = 4'($urandom);
      bus.cmd_last  = 4'($urandom);
      hs = bus.in_valid && bus.in_ready;
      tick();
      if (hs) void'(in_q.pop_front());
    end
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("timeout", {31'd0, fin}, 1);
    check("done_level", {31'd0, bus.done}, {31'd0, !exp_err});
    check("err_level", {31'd0, bus.err}, {31'd0, exp_err});
    tick();
    check("busy_after", {31'd0, bus.busy}, 0);
    check("cmd_ready_after", {31'd0, bus.cmd_ready}, 1);
    check("pulse_end", {30'd0, bus.done, bus.err}, 0);
    check("done_cnt", done_cnt - d0, exp_err ? 0 : 1);
    check("err_cnt", err_cnt - e0, exp_err ? 1 : 0);
    check("rd_cnt", rd_cnt - r0, op ? 0 : n);
    check("wr_cnt", wr_cnt - w0, op ? n : 0);
    if (!op) begin
      check("word_cnt", got_words.size() - g0, exp_q.size());
      for (int i = 0; i < exp_q.size() && g0 + i < got_words.size(); i++)
        check("save_word", {16'd0, got_words[g0 + i]}, {16'd0, exp_q[i]});
    end else begin
      check("in_drained", in_q.size(), 0);
      for (int i = 0; i < dat.size(); i++) ref_regs[first + i] = dat[i];
      for (int i = 0; i < 16; i++) check("reg_content", {16'd0, rf_mem[i]}, {16'd0, ref_regs[i]});
    end
    check("protocol_counts", overlap_cnt + hold_bad_cnt + hi_bad_cnt + lane_bad_cnt, 0);
  endtask

  initial begin
    int d0, g0;
    logic [15:0] dq[$];
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_first = '0;
    bus.cmd_last  = '0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.rf_data_in = '0;
    for (int i = 0; i < 16; i++) ref_regs[i] = 16'(16'h1000 + i);
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
    tick();
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    check("rst_outputs", {bus.busy, bus.done, bus.err, bus.out_valid, bus.in_ready,
                          bus.rf_rd_en, bus.rf_wr_en}, 0);
    check("rst_data", {bus.out_data, bus.rf_data_out}, 0);
    @(negedge clock);
    nreset = 1'b1;
    tick();

    do_op(1'b0, 0, 15, 0, none, 1'b0, '0);
    do_op(1'b0, 3, 5, 2, none, 1'b0, '0);
    dq = '{16'hBEEF, 16'hCAFE};
    do_op(1'b1, 14, 15, 1, dq, 1'b0, '0);
    do_op(1'b0, 15, 15, 1, none, 1'b0, '0);
    do_op(1'b0, 9, 2, 0, none, 1'b0, '0);

    // Reset during a long save: abandon without a done pulse.
    d0 = done_cnt;
    g0 = got_words.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b0;
    bus.cmd_first = 4'd0;
    bus.cmd_last  = 4'd15;
    tick();
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got_words.size() - g0 < 4; cyc++) tick();
    check("pre_reset_words", got_words.size() - g0, 4);
    nreset = 1'b0;
    #1;
    check("abort_outputs", {bus.busy, bus.done, bus.err, bus.out_valid, bus.in_ready,
                            bus.rf_rd_en, bus.rf_wr_en}, 0);
    check("abort_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    bus.out_ready = 1'b0;
    tick();
    tick();
    @(negedge clock);
    nreset = 1'b1;
    tick();
    check("abort_no_done", done_cnt - d0, 0);
    do_op(1'b0, 0, 0, 0, none, 1'b0, '0);

    dq = '{16'h00FF, 16'h0F0F};
    do_op(1'b1, 0, 1, 1, dq, 1'b0, '0);
    g0 = got_words.size();
    do_op(1'b0, 0, 1, 0, none, 1'b0, '0);
`ifdef REGFILE_CTX_CHECKSUM_EN
    if (got_words.size() >= g0 + 3) check("chk_word", {16'd0, got_words[g0 + 2]}, 32'h0FF0);
    else check("chk_word_present", got_words.size() - g0, 3);
    dq = '{16'h1234, 16'h5678};
    do_op(1'b1, 0, 1, 1, dq, 1'b1, 16'h0000);
`endif

    for (int t = 0; t < 30; t++) begin
      int f, l, m;
      f = $urandom_range(0, 15);
      l = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(f, 15);
      m = ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 1);
      do_op(1'($urandom), f, l, m, none, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
